// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg
// Shared types and constants for the DDR worker arbiter.
//   arb_state_e   : arbiter FSM state
//   ddr_addr_t    : 64-bit DDR word address (4-bit base + 25-bit offset)
//   ddr_burst_t   : burst count
//   DDR_CORE_BASE : base nibble of the core's DDR window
package ddr_arb_pkg;

    localparam int DDR_ADDR_W  = 29;
    localparam int DDR_BURST_W = 8;

    localparam logic [3:0] DDR_CORE_BASE = 4'b0011;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        DRAIN
    } arb_state_e;

    typedef logic [DDR_ADDR_W-1:0]  ddr_addr_t;
    typedef logic [DDR_BURST_W-1:0] ddr_burst_t;

endpackage

// File: rtl/ddr_arb_rr_picker.sv
// ddr_arb_rr_picker
// Combinational cyclic-priority pick. It grants the first requester found at or
// after rr_ptr_i, wrapping around.
//   req_i       : per-host request vector
//   rr_ptr_i    : index with highest priority
//   grant_idx_o : chosen host (0 when nothing is requested)
//   grant_any_o : at least one request present
module ddr_arb_rr_picker #(
    parameter int NUM_HOSTS = 4,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_HOSTS-1:0] req_i,
    input  logic [PTR_W-1:0]     rr_ptr_i,
    output logic [PTR_W-1:0]     grant_idx_o,
    output logic                 grant_any_o
);

    always_comb begin : pick
        int cand;
        cand        = 0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        // Scan from the farthest candidate back to rr_ptr so that the closest
        // requester is the last to overwrite the result.
        for (int i = NUM_HOSTS - 1; i >= 0; i--) begin
            cand = (int'(rr_ptr_i) + i) % NUM_HOSTS;
            if (req_i[cand]) begin
                grant_any_o = 1'b1;
                grant_idx_o = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/ddr_worker_arbiter.sv
// ddr_worker_arbiter
// Merges NUM_HOSTS worker host ports onto one DDR port. Grants use round-robin
// and hold while the owner keeps acquire asserted. Read beats are routed to the
// owner only. Beats that are still outstanding after a release are absorbed
// in DRAIN.
// Ports:
//   clk_mpeg_i, reset_n_clk_mpeg_i : clock, async active-low reset
//   host_*_i                       : per-host request, lock and data
//   host_busy_o                    : per-host stall
//   host_rdata_ready_o             : read beat valid (owner only)
//   host_rdata_o                   : read data, broadcast to all hosts
//   ddr_*_o / ddr_*_i              : downstream DDR port
//   grant_count_o                  : per-host grant counters (only when
//                                    DDR_ARB_STATS_EN is defined)
module ddr_worker_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NUM_HOSTS = 4,
    parameter int ADDR_W    = DDR_ADDR_W,
    parameter int BURST_W   = DDR_BURST_W
) (
    input  logic                              clk_mpeg_i,
    input  logic                              reset_n_clk_mpeg_i,
    input  logic [NUM_HOSTS-1:0]              host_acquire_i,
    input  logic [NUM_HOSTS-1:0]              host_read_i,
    input  logic [NUM_HOSTS-1:0]              host_write_i,
    input  logic [NUM_HOSTS-1:0][ADDR_W-1:0]  host_addr_i,
    input  logic [NUM_HOSTS-1:0][BURST_W-1:0] host_burstcnt_i,
    input  logic [NUM_HOSTS-1:0][63:0]        host_wdata_i,
    input  logic [NUM_HOSTS-1:0][7:0]         host_byteenable_i,
    output logic [NUM_HOSTS-1:0]              host_busy_o,
    output logic [NUM_HOSTS-1:0]              host_rdata_ready_o,
    output logic [63:0]                       host_rdata_o,
    output logic                              ddr_read_o,
    output logic                              ddr_write_o,
    output logic [ADDR_W-1:0]                 ddr_addr_o,
    output logic [BURST_W-1:0]                ddr_burstcnt_o,
    output logic [63:0]                       ddr_wdata_o,
    output logic [7:0]                        ddr_byteenable_o,
    input  logic                              ddr_busy_i,
    input  logic [63:0]                       ddr_rdata_i,
    input  logic                              ddr_rdata_ready_i
`ifdef DDR_ARB_STATS_EN
    ,
    output logic [NUM_HOSTS-1:0][15:0]        grant_count_o
`endif
);

    localparam int PTR_W  = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1;
    // Headroom for several reads accepted back to back before their beats return.
    localparam int BEAT_W = BURST_W + 4;

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [PTR_W-1:0]  owner_next;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_any;
    logic [BEAT_W-1:0] beats_left_q, beats_left_d, beats_sum;
    logic [BURST_W-1:0] burst_eff;
    logic              read_accept;

    ddr_arb_rr_picker #(
        .NUM_HOSTS (NUM_HOSTS),
        .PTR_W     (PTR_W)
    ) u_picker (
        .req_i       (host_acquire_i),
        .rr_ptr_i    (rr_ptr_q),
        .grant_idx_o (grant_idx),
        .grant_any_o (grant_any)
    );

    assign owner_next  = (int'(owner_q) == NUM_HOSTS - 1) ? '0 : owner_q + PTR_W'(1);
    // A zero burst count still returns one beat.
    assign burst_eff   = (host_burstcnt_i[owner_q] == '0) ? BURST_W'(1) : host_burstcnt_i[owner_q];
    assign read_accept = (state_q == OWN) && host_acquire_i[owner_q] &&
                         host_read_i[owner_q] && !ddr_busy_i;

    assign host_rdata_o = ddr_rdata_i;

    // A beat in the same cycle as a read accept is taken from the new total.
    // A beat that arrives with nothing outstanding is dropped (saturates at 0).
    always_comb begin : beat_count
        beats_sum    = beats_left_q + (read_accept ? BEAT_W'(burst_eff) : '0);
        beats_left_d = beats_sum;
        if (ddr_rdata_ready_i && (beats_sum != '0)) begin
            beats_left_d = beats_sum - BEAT_W'(1);
        end
    end

    always_comb begin : fsm_next
        state_d            = state_q;
        rr_ptr_d           = rr_ptr_q;
        owner_d            = owner_q;
        host_busy_o        = '1;
        host_rdata_ready_o = '0;
        ddr_read_o         = 1'b0;
        ddr_write_o        = 1'b0;
        ddr_addr_o         = '0;
        ddr_burstcnt_o     = '0;
        ddr_wdata_o        = '0;
        ddr_byteenable_o   = '0;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    owner_d = grant_idx;
                    state_d = OWN;
                end
            end
            OWN: begin
                ddr_read_o                  = host_read_i[owner_q] & host_acquire_i[owner_q];
                ddr_write_o                 = host_write_i[owner_q] & host_acquire_i[owner_q];
                ddr_addr_o                  = host_addr_i[owner_q];
                ddr_burstcnt_o              = host_burstcnt_i[owner_q];
                ddr_wdata_o                 = host_wdata_i[owner_q];
                ddr_byteenable_o            = host_byteenable_i[owner_q];
                host_busy_o[owner_q]        = ddr_busy_i;
                host_rdata_ready_o[owner_q] = ddr_rdata_ready_i;
                if (!host_acquire_i[owner_q]) begin
                    if (beats_left_d == '0) begin
                        state_d  = IDLE;
                        rr_ptr_d = owner_next;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (beats_left_d == '0) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_mpeg_i or negedge reset_n_clk_mpeg_i) begin
        if (!reset_n_clk_mpeg_i) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            beats_left_q <= beats_left_d;
        end
    end

`ifdef DDR_ARB_STATS_EN
    always_ff @(posedge clk_mpeg_i or negedge reset_n_clk_mpeg_i) begin
        if (!reset_n_clk_mpeg_i) begin
            grant_count_o <= '0;
        end else if ((state_q == IDLE) && grant_any) begin
            grant_count_o[grant_idx] <= grant_count_o[grant_idx] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr_worker_arbiter.sv
// tb_ddr_worker_arbiter
// Self-checking bench for ddr_worker_arbiter (NUM_HOSTS=4). The bench drives
// inputs on the falling edge and samples outputs before the next rising edge.
// A reference model runs in lockstep with the DUT. It is written in terms of
// the owner index, the beats still outstanding and the round-robin start
// point. The grant-counter check needs DDR_ARB_STATS_EN.
module tb_ddr_worker_arbiter;
    import ddr_arb_pkg::*;

    logic               clk;
    logic               rst_n;
    logic [3:0]         acq, rd, wr;
    ddr_addr_t [3:0]    addr;
    ddr_burst_t [3:0]   burst;
    logic [3:0][63:0]   wdata;
    logic [3:0][7:0]    be;
    logic [3:0]         host_busy, host_rrdy;
    logic [63:0]        host_rdata;
    logic               ddr_read, ddr_write;
    ddr_addr_t          ddr_addr;
    ddr_burst_t         ddr_burstcnt;
    logic [63:0]        ddr_wdata;
    logic [7:0]         ddr_be;
    logic               ddr_busy;
    logic [63:0]        ddr_rdata;
    logic               ddr_rdy;
`ifdef DDR_ARB_STATS_EN
    logic [3:0][15:0]   gc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_owner;   // -1 when no host holds the bus
    bit m_drain;
    int m_beats;
    int m_rr;

    ddr_worker_arbiter #(.NUM_HOSTS(4), .ADDR_W(29), .BURST_W(8)) dut (
        .clk_mpeg_i         (clk),
        .reset_n_clk_mpeg_i (rst_n),
        .host_acquire_i     (acq),
        .host_read_i        (rd),
        .host_write_i       (wr),
        .host_addr_i        (addr),
        .host_burstcnt_i    (burst),
        .host_wdata_i       (wdata),
        .host_byteenable_i  (be),
        .host_busy_o        (host_busy),
        .host_rdata_ready_o (host_rrdy),
        .host_rdata_o       (host_rdata),
        .ddr_read_o         (ddr_read),
        .ddr_write_o        (ddr_write),
        .ddr_addr_o         (ddr_addr),
        .ddr_burstcnt_o     (ddr_burstcnt),
        .ddr_wdata_o        (ddr_wdata),
        .ddr_byteenable_o   (ddr_be),
        .ddr_busy_i         (ddr_busy),
        .ddr_rdata_i        (ddr_rdata),
        .ddr_rdata_ready_i  (ddr_rdy)
`ifdef DDR_ARB_STATS_EN
        ,
        .grant_count_o      (gc)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_drain = 1'b0;
        m_beats = 0;
        m_rr    = 0;
    endtask

    // Expected outputs for the current inputs and model state.
    task automatic cmp_model();
        logic [3:0]  e_busy, e_rrdy;
        logic        e_rd, e_wr;
        ddr_addr_t   e_addr;
        ddr_burst_t  e_burst;
        logic [63:0] e_wd;
        logic [7:0]  e_be;
        int          o;
        e_busy = 4'hF; e_rrdy = 4'h0; e_rd = 1'b0; e_wr = 1'b0;
        e_addr = '0; e_burst = '0; e_wd = '0; e_be = '0;
        if (m_owner >= 0 && !m_drain) begin
            o         = m_owner;
            e_busy[o] = ddr_busy;
            e_rrdy[o] = ddr_rdy;
            e_rd      = acq[o] & rd[o];
            e_wr      = acq[o] & wr[o];
            e_addr    = addr[o];
            e_burst   = burst[o];
            e_wd      = wdata[o];
            e_be      = be[o];
        end
        chk("model_ctl", {host_busy, host_rrdy, ddr_read, ddr_write}, {e_busy, e_rrdy, e_rd, e_wr});
        chk("model_addr_burst", {ddr_addr, ddr_burstcnt}, {e_addr, e_burst});
        chk("model_wdata", ddr_wdata, e_wd);
        chk("model_be", ddr_be, e_be);
        chk("model_rdata", host_rdata, ddr_rdata);
    endtask

    // Advance the model by one rising edge using the inputs applied this cycle.
    task automatic model_step();
        int b, h;
        if (m_owner < 0) begin
            for (int i = 0; i < 4; i++) begin
                h = (m_rr + i) % 4;
                if (acq[h]) begin
                    m_owner = h;
                    m_drain = 1'b0;
                    break;
                end
            end
        end else if (!m_drain) begin
            b = m_beats;
            if (acq[m_owner] && rd[m_owner] && !ddr_busy)
                b += (burst[m_owner] == 0) ? 1 : int'(burst[m_owner]);
            if (ddr_rdy && b > 0) b--;
            m_beats = b;
            if (!acq[m_owner]) begin
                if (b == 0) begin
                    m_rr    = (m_owner + 1) % 4;
                    m_owner = -1;
                end else begin
                    m_drain = 1'b1;
                end
            end
        end else begin
            if (ddr_rdy && m_beats > 0) m_beats--;
            if (m_beats == 0) begin
                m_rr    = (m_owner + 1) % 4;
                m_owner = -1;
                m_drain = 1'b0;
            end
        end
    endtask

    // Called just after a falling edge with the inputs already applied.
    task automatic cyc();
        #2;
        cmp_model();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        acq = '0; rd = '0; wr = '0;
        ddr_busy = 1'b0; ddr_rdy = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        chk("rst_ctl", {host_busy, host_rrdy, ddr_read, ddr_write}, {4'hF, 4'h0, 2'b00});
        chk("rst_bus", {ddr_addr, ddr_burstcnt, ddr_be}, '0);
        chk("rst_wdata", ddr_wdata, '0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] acq, rd, wr;
        logic       dbusy, rdy;
        logic [3:0] e_busy, e_rrdy;
        logic       e_rd, e_wr;
    } vec_t;

    vec_t tbl[18];
    int   exp_ord[3];
    int   order[$];
    int   w;

    initial begin
        // single read by host 1, host 3 wins over host 0 from rr_ptr=2,
        // then host 0 releases early and its remaining beats drain
        tbl[0]  = '{4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b1101, 4'b0000, 1'b1, 1'b0};
        tbl[2]  = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1101, 4'b0010, 1'b0, 1'b0};
        tbl[3]  = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1101, 4'b0010, 1'b0, 1'b0};
        tbl[4]  = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1101, 4'b0010, 1'b0, 1'b0};
        tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1101, 4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{4'b1001, 4'b0000, 4'b1001, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0};
        tbl[7]  = '{4'b1001, 4'b0000, 4'b1001, 1'b0, 1'b0, 4'b0111, 4'b0000, 1'b0, 1'b1};
        tbl[8]  = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0111, 4'b0000, 1'b0, 1'b0};
        tbl[9]  = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0};
        tbl[10] = '{4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0};
        tbl[11] = '{4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b1110, 4'b0000, 1'b1, 1'b0};
        tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1110, 4'b0001, 1'b0, 1'b0};
        tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0};
        tbl[14] = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0};
        tbl[15] = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0};
        tbl[16] = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0};
        tbl[17] = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1101, 4'b0000, 1'b0, 1'b0};
        exp_ord = '{0, 2, 3};

        rst_n = 1'b0;
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            addr[i]  = ddr_addr_t'(29'h100 * (i + 1));
            burst[i] = 8'd3;
            wdata[i] = {32'hA5A5_0000 + i, 32'h1234_0000 + i};
            be[i]    = 8'hF0 | 8'(i);
        end
        addr[1]   = 29'h3000010;
        ddr_rdata = 64'h0;
        @(negedge clk);

        // table-driven sequence
        do_reset();
        for (int r = 0; r < 18; r++) begin
            acq = tbl[r].acq; rd = tbl[r].rd; wr = tbl[r].wr;
            ddr_busy = tbl[r].dbusy; ddr_rdy = tbl[r].rdy;
            ddr_rdata = {$urandom(), $urandom()};
            #1;
            chk($sformatf("tbl_row%0d", r), {host_busy, host_rrdy, ddr_read, ddr_write},
                {tbl[r].e_busy, tbl[r].e_rrdy, tbl[r].e_rd, tbl[r].e_wr});
            if (r == 1) chk("tbl_addr", ddr_addr, 29'h3000010);
            cyc();
        end

        // contention: hosts 0,2,3 each write once and release
        do_reset();
        acq = 4'b1101; wr = 4'b1101;
        order.delete();
        for (int c = 0; c < 40 && order.size() < 3; c++) begin
            w = -1;
            #1;
            if (ddr_write) begin
                for (int i = 0; i < 4; i++) if (!host_busy[i]) w = i;
            end
            cyc();
            if (w >= 0) begin
                order.push_back(w);
                acq[w] = 1'b0;
                wr[w]  = 1'b0;
            end
        end
        chk("cont_grants", 64'(order.size()), 64'd3);
        for (int k = 0; k < order.size() && k < 3; k++)
            chk($sformatf("cont_order%0d", k), 64'(order[k]), 64'(exp_ord[k]));

        // backpressure on a write by host 2
        do_reset();
        acq = 4'b0100; wr = 4'b0100; wdata[2] = 64'hDEAD_BEEF_0123_4567; ddr_busy = 1'b1;
        cyc();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_stall", {host_busy[2], ddr_write}, 2'b11);
            chk("bp_wdata", ddr_wdata, 64'hDEAD_BEEF_0123_4567);
            cyc();
        end
        ddr_busy = 1'b0;
        #1;
        chk("bp_done", {host_busy[2], ddr_write}, 2'b01);
        cyc();
        acq = '0; wr = '0;
        cyc();

        // reset during beat 2 of a 3-beat read by host 1
        do_reset();
        acq = 4'b0010; rd = 4'b0010;
        cyc();
        cyc();
        rd = '0; ddr_rdy = 1'b1;
        cyc();
        #2;
        chk("mid_beat2", host_rrdy, 4'b0010);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {host_busy, host_rrdy, ddr_read, ddr_write}, {4'hF, 4'h0, 2'b00});
        chk("mid_rst_bus", {ddr_addr, ddr_burstcnt, ddr_be}, '0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acq = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stray_rrdy", host_rrdy, 4'b0000);
            cyc();
        end
        ddr_rdy = 1'b0; acq = 4'b1000;
        cyc();
        #1;
        chk("post_rst_grant", host_busy, 4'b0111);
        cyc();

`ifdef DDR_ARB_STATS_EN
        do_reset();
        for (int k = 0; k < 5; k++) begin
            acq = 4'b0100;
            cyc();
            acq = 4'b0000;
            cyc();
        end
        #1;
        chk("stats_gc2", 64'(gc[2]), 64'd5);
        chk("stats_others", {gc[3], gc[1], gc[0]}, '0);
        cyc();
`endif

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) acq[i] = ~acq[i];
                rd[i]    = 1'($urandom_range(0, 1));
                wr[i]    = 1'($urandom_range(0, 1));
                addr[i]  = ddr_addr_t'($urandom());
                burst[i] = ddr_burst_t'($urandom_range(0, 3));
                wdata[i] = {$urandom(), $urandom()};
                be[i]    = 8'($urandom());
            end
            ddr_busy  = ($urandom_range(0, 9) < 3);
            ddr_rdy   = ($urandom_range(0, 9) < 4);
            ddr_rdata = {$urandom(), $urandom()};
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
